// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES-128 encrypt datapath: it drives the state/key register enables,
// the mux selects and the round number for one encryption. Optional run abort: AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl #(
    parameter int NROUNDS  = 10,
    parameter int SBOX_LAT = 1,
    parameter int RW       = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          load_i,
    output logic          state_sel_o,
    output logic          key_sel_o,
    output logic          state_we_o,
    output logic          key_we_o,
    output logic          sbox_en_o,
    output logic          last_round_o,
    output logic [RW-1:0] round_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_INIT  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0]    PH_LAST  = 2'(SBOX_LAT);
    localparam logic [RW-1:0] RND_LAST = RW'(NROUNDS);

    logic [1:0]    state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [RW-1:0] round_q, round_d;
    logic          load_q;

    logic start;
    logic abort;
    logic ph_end;
    logic rnd_end;

    // A run starts on the falling edge of load, i.e. once SPI has finished shifting.
    assign start   = load_q & ~load_i;
    assign ph_end  = (phase_q == PH_LAST);
    assign rnd_end = (round_q == RND_LAST);

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abort = load_i;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        round_d = round_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    phase_d = '0;
                    round_d = '0;
                end
            end
            S_INIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                    round_d = '0;
                end else begin
                    state_d = S_ROUND;
                    phase_d = '0;
                    round_d = RW'(1);
                end
            end
            S_ROUND: begin
                if (abort) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                    round_d = '0;
                end else if (ph_end) begin
                    phase_d = '0;
                    // round stays at NROUNDS in DONE so the core can still read it
                    if (rnd_end) state_d = S_DONE;
                    else         round_d = round_q + RW'(1);
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_INIT;
                    phase_d = '0;
                    round_d = '0;
                end else if (load_i) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                    round_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
                round_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            round_q <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            round_q <= round_d;
            load_q  <= load_i;
        end
    end

    // Moore decode only: nothing here looks at load_i.
    assign state_sel_o  = (state_q == S_INIT);
    assign key_sel_o    = (state_q == S_INIT);
    assign state_we_o   = (state_q == S_INIT) | ((state_q == S_ROUND) & ph_end);
    assign key_we_o     = (state_q == S_INIT) | ((state_q == S_ROUND) & ph_end);
    assign sbox_en_o    = (state_q == S_ROUND) & (phase_q == 2'd0);
    assign last_round_o = (state_q == S_ROUND) & rnd_end;
    assign busy_o       = (state_q == S_INIT) | (state_q == S_ROUND);
    assign done_o       = (state_q == S_DONE);
    assign round_o      = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: default, SBOX_LAT=0 and SBOX_LAT=2 instances side by side.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load_def = 1'b0, load_l0 = 1'b0, load_l2 = 1'b0;

    logic ss_d, ks_d, sw_d, kw_d, sb_d, lr_d, bz_d, dn_d;
    logic ss_0, ks_0, sw_0, kw_0, sb_0, lr_0, bz_0, dn_0;
    logic ss_2, ks_2, sw_2, kw_2, sb_2, lr_2, bz_2, dn_2;
    logic [3:0] rn_d, rn_0, rn_2;

    int checks = 0;
    int failures = 0;

    logic [7:0] cap_o [0:63];
    logic [3:0] cap_r [0:63];
    int cap_n;
    int cap_lat;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NROUNDS(10), .SBOX_LAT(1), .RW(4)) u_def (
        .clk_i(clk), .reset_i(reset), .load_i(load_def),
        .state_sel_o(ss_d), .key_sel_o(ks_d), .state_we_o(sw_d), .key_we_o(kw_d),
        .sbox_en_o(sb_d), .last_round_o(lr_d), .round_o(rn_d), .busy_o(bz_d), .done_o(dn_d));

    aes_round_ctrl #(.NROUNDS(10), .SBOX_LAT(0), .RW(4)) u_l0 (
        .clk_i(clk), .reset_i(reset), .load_i(load_l0),
        .state_sel_o(ss_0), .key_sel_o(ks_0), .state_we_o(sw_0), .key_we_o(kw_0),
        .sbox_en_o(sb_0), .last_round_o(lr_0), .round_o(rn_0), .busy_o(bz_0), .done_o(dn_0));

    aes_round_ctrl #(.NROUNDS(10), .SBOX_LAT(2), .RW(4)) u_l2 (
        .clk_i(clk), .reset_i(reset), .load_i(load_l2),
        .state_sel_o(ss_2), .key_sel_o(ks_2), .state_we_o(sw_2), .key_we_o(kw_2),
        .sbox_en_o(sb_2), .last_round_o(lr_2), .round_o(rn_2), .busy_o(bz_2), .done_o(dn_2));

    // bit 7..0: state_sel key_sel state_we key_we sbox_en last_round busy done
    function automatic logic [7:0] obs(input int w);
        case (w)
            1:       return {ss_0, ks_0, sw_0, kw_0, sb_0, lr_0, bz_0, dn_0};
            2:       return {ss_2, ks_2, sw_2, kw_2, sb_2, lr_2, bz_2, dn_2};
            default: return {ss_d, ks_d, sw_d, kw_d, sb_d, lr_d, bz_d, dn_d};
        endcase
    endfunction

    function automatic logic [3:0] obsr(input int w);
        case (w)
            1:       return rn_0;
            2:       return rn_2;
            default: return rn_d;
        endcase
    endfunction

    // Expected outputs k cycles after INIT for a 10-round run with S-box latency lat.
    function automatic logic [7:0] exp_o(input int k, input int lat);
        int r, p;
        if (k == 0) return 8'b1111_0010;
        if (k <= 10 * (lat + 1)) begin
            r = (k - 1) / (lat + 1) + 1;
            p = (k - 1) % (lat + 1);
            return {2'b00, p == lat, p == lat, p == 0, r == 10, 1'b1, 1'b0};
        end
        return 8'b0000_0001;
    endfunction

    function automatic logic [3:0] exp_r(input int k, input int lat);
        if (k == 0) return 4'd0;
        if (k <= 10 * (lat + 1)) return 4'((k - 1) / (lat + 1) + 1);
        return 4'd10;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input int w, input logic v);
        case (w)
            1:       load_l0 = v;
            2:       load_l2 = v;
            default: load_def = v;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load_def = 1'b0; load_l0 = 1'b0; load_l2 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    // Leaves instance w in its INIT cycle.
    task automatic start_run(input int w);
        set_load(w, 1'b1);
        tick();
        set_load(w, 1'b0);
        tick();
    endtask

    // Records outputs from the current cycle until done or maxc cycles.
    task automatic capture(input int w, input int maxc);
        cap_n = 0;
        cap_lat = -1;
        for (int k = 0; k < maxc; k++) begin
            cap_o[k] = obs(w);
            cap_r[k] = obsr(w);
            cap_n = k + 1;
            if (cap_o[k][0]) begin
                cap_lat = k;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (obs(w) !== 8'h00 || obsr(w) !== 4'd0) begin
                failures++;
                $display("FAIL reset_state inst=%0d got=%b/%0d exp=00000000/0", w, obs(w), obsr(w));
            end
        end
        reset = 1'b0;
        load_def = 1'b1;
        repeat (4) tick();
        checks++;
        if (obs(0) !== 8'h00) begin
            failures++;
            $display("FAIL idle_load_high got=%b exp=00000000", obs(0));
        end
        load_def = 1'b0;
        tick();
        checks++;
        if (obs(0) !== 8'b1111_0010 || obsr(0) !== 4'd0) begin
            failures++;
            $display("FAIL idle_fall_init got=%b/%0d exp=11110010/0", obs(0), obsr(0));
        end
    endtask

    task automatic check_run(input string name, input int lat);
        int swe, kwe, bad, first_bad;
        swe = 0; kwe = 0; bad = 0; first_bad = -1;
        for (int k = 0; k < cap_n; k++) begin
            swe += int'(cap_o[k][5]);
            kwe += int'(cap_o[k][4]);
            if (cap_o[k] !== exp_o(k, lat) || cap_r[k] !== exp_r(k, lat)) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        checks++;
        if (cap_lat !== 1 + 10 * (lat + 1)) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=%0d", name, cap_lat, 1 + 10 * (lat + 1));
        end
        checks++;
        if (swe !== 11 || kwe !== 11) begin
            failures++;
            $display("FAIL %s_we_count got=%0d/%0d exp=11/11", name, swe, kwe);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL %s_sequence bad_cycles=%0d first=%0d got=%b/%0d exp=%b/%0d", name, bad,
                     first_bad, cap_o[first_bad], cap_r[first_bad], exp_o(first_bad, lat),
                     exp_r(first_bad, lat));
        end
    endtask

    task automatic test_default_run();
        do_reset();
        start_run(0);
        capture(0, 40);
        check_run("default", 1);
        repeat (3) tick();
        checks++;
        if (obs(0) !== 8'b0000_0001 || obsr(0) !== 4'd10) begin
            failures++;
            $display("FAIL done_hold got=%b/%0d exp=00000001/10", obs(0), obsr(0));
        end
    endtask

    task automatic test_back_to_back();
        load_def = 1'b1;
        tick();
        checks++;
        if (dn_d !== 1'b0 || rn_d !== 4'd0) begin
            failures++;
            $display("FAIL done_drop got=%b/%0d exp=0/0", dn_d, rn_d);
        end
        load_def = 1'b0;
        tick();
        capture(0, 40);
        check_run("rerun", 1);
    endtask

    task automatic test_reset_midrun();
        int swe, dn;
        do_reset();
        start_run(0);
        repeat (10) tick();
        checks++;
        if (rn_d !== 4'd5 || sw_d !== 1'b1) begin
            failures++;
            $display("FAIL midrun_position got=round%0d/we%b exp=round5/we1", rn_d, sw_d);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (obs(0) !== 8'h00 || obsr(0) !== 4'd0) begin
            failures++;
            $display("FAIL midrun_reset got=%b/%0d exp=00000000/0", obs(0), obsr(0));
        end
        reset = 1'b0;
        swe = 0; dn = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            swe += int'(sw_d);
            dn += int'(dn_d);
        end
        checks++;
        if (swe !== 0 || dn !== 0) begin
            failures++;
            $display("FAIL after_reset_quiet got=we%0d/done%0d exp=we0/done0", swe, dn);
        end
        // load falling on the same edge as reset must not start a run
        load_def = 1'b1;
        tick();
        reset = 1'b1;
        load_def = 1'b0;
        tick();
        reset = 1'b0;
        swe = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            swe += int'(bz_d);
        end
        checks++;
        if (swe !== 0) begin
            failures++;
            $display("FAIL reset_load_edge busy_cycles got=%0d exp=0", swe);
        end
    endtask

    task automatic test_load_during_run();
        do_reset();
        start_run(0);
        repeat (5) tick();
        checks++;
        if (rn_d !== 4'd3) begin
            failures++;
            $display("FAIL abort_position got=%0d exp=3", rn_d);
        end
        load_def = 1'b1;
`ifdef AES_ROUND_CTRL_ABORT_EN
        tick();
        checks++;
        if (obs(0) !== 8'h00 || obsr(0) !== 4'd0) begin
            failures++;
            $display("FAIL abort_idle got=%b/%0d exp=00000000/0", obs(0), obsr(0));
        end
        load_def = 1'b0;
        tick();
        checks++;
        if (obs(0) !== 8'b1111_0010) begin
            failures++;
            $display("FAIL abort_restart got=%b exp=11110010", obs(0));
        end
`else
        capture(0, 40);
        checks++;
        if (cap_lat !== 16) begin
            failures++;
            $display("FAIL ignore_load_latency got=%0d exp=16", cap_lat);
        end
        tick();
        checks++;
        if (dn_d !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width got=%b exp=0", dn_d);
        end
        // falling edge mid-run is not queued
        do_reset();
        start_run(0);
        repeat (5) tick();
        load_def = 1'b1;
        repeat (4) tick();
        load_def = 1'b0;
        capture(0, 40);
        repeat (4) tick();
        checks++;
        if (cap_lat !== 12 || obs(0) !== 8'b0000_0001) begin
            failures++;
            $display("FAIL no_queue got=lat%0d/%b exp=lat12/00000001", cap_lat, obs(0));
        end
`endif
    endtask

    task automatic test_sbox_lat();
        do_reset();
        start_run(1);
        capture(1, 40);
        check_run("lat0", 0);
        do_reset();
        start_run(2);
        capture(2, 50);
        check_run("lat2", 2);
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_back_to_back();
        test_reset_midrun();
        test_load_during_run();
        test_sbox_lat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
